// File: rtl/color_fsm_sequencer.sv
// color_fsm_sequencer: round-robin arbiter and command sequencer for the
// Color/HSV state machine. Keeps a shadow of the machine's state, steps it
// to the requested target, checks the output code, and acknowledges the requester.
module color_fsm_sequencer #(
   parameter int unsigned NUM_REQ     = 2,
   parameter logic [1:0]  RESET_STATE = 2'h1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [2*NUM_REQ-1:0]   tgt,
   output logic [NUM_REQ-1:0]     ack,
   output logic                   err,
   output logic [1:0]             fsm_in,
   input  logic [1:0]             fsm_out,
   output logic [1:0]             cur_state,
   output logic                   busy,
   output logic                   fault
);

   localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, STEP, CHECK, DONE} state_t;
   typedef enum logic [1:0] {BLUE, RED, HSV, INVALID} color_t;

   state_t        state, state_nx;
   color_t        shadow, target, step_next, gnt_tgt;
   logic [1:0]    step_code, exp_code;
   logic [IW-1:0] idx, last, gnt_idx;
   logic          gnt_valid, err_r, fault_r;

   // Round-robin pick: scan from the requester after the last grant
   always_comb begin
      int unsigned          cand;
      logic [NUM_REQ-1:0]   rbits;
      logic [2*NUM_REQ-1:0] tbits;
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      gnt_tgt   = INVALID;
      cand      = 0;
      rbits     = '0;
      tbits     = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand  = (32'(last) + k) % NUM_REQ;
         rbits = req >> cand;
         tbits = tgt >> (2 * cand);
         if (!gnt_valid && rbits[0]) begin
            gnt_valid = 1'b1;
            gnt_idx   = IW'(cand);
            gnt_tgt   = color_t'(tbits[1:0]);
         end
      end
   end

   // Step table: command code and resulting shadow for the current move
   always_comb begin
      step_code = 2'd3;
      step_next = shadow;
      case (shadow)
         BLUE: begin
            step_code = 2'd1;
            step_next = RED;
         end
         RED: begin
            if (target == BLUE) begin
               step_code = 2'd1;
               step_next = BLUE;
            end else if (target == HSV) begin
               step_code = 2'd2;
               step_next = HSV;
            end
         end
         HSV: begin
            step_code = 2'd0;
            step_next = RED;
         end
         default: ;
      endcase
      exp_code = (target == BLUE) ? 2'd1 : 2'd2;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (gnt_valid) begin
               if (gnt_tgt == INVALID || fault_r) state_nx = DONE;
               else if (gnt_tgt == shadow)        state_nx = CHECK;
               else                               state_nx = STEP;
            end
         end
         STEP:    state_nx = (step_next == target) ? CHECK : STEP;
         CHECK:   state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath: grant latch, shadow update, result and fault tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow  <= color_t'(RESET_STATE);
         target  <= RED;
         idx     <= '0;
         last    <= IW'(NUM_REQ - 1);
         err_r   <= 1'b0;
         fault_r <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_valid) begin
                  idx    <= gnt_idx;
                  target <= gnt_tgt;
                  err_r  <= (gnt_tgt == INVALID) || fault_r;
               end
            end
            STEP: shadow <= step_next;
            CHECK: begin
               if (fsm_out != exp_code) begin
                  err_r   <= 1'b1;
                  fault_r <= 1'b1;
               end
            end
            DONE: last <= idx;
            default: ;
         endcase
      end
   end

   // Outputs decoded from the current state
   always_comb begin
      fsm_in    = 2'd3;
      ack       = '0;
      err       = 1'b0;
      busy      = (state != IDLE);
      cur_state = shadow;
      fault     = fault_r;
      if (state == STEP) fsm_in = step_code;
      if (state == DONE) begin
         ack = NUM_REQ'(1) << idx;
         err = err_r;
      end
   end

endmodule

// File: tb/tb_color_fsm_sequencer.sv
// Bench for color_fsm_sequencer: behavioural model of the controlled Color/HSV
// machine plus a scoreboard of expected acks (index, err, latency, commands).
module tb_color_fsm_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] req;
   logic [3:0] tgt;
   logic [1:0] ack;
   logic       err;
   logic [1:0] fsm_in;
   logic [1:0] fsm_out;
   logic [1:0] cur_state;
   logic       busy;
   logic       fault;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int         idx;
      bit         err;
      int         lat;
      logic [7:0] cmds;
      logic [1:0] st;
      bit         flt;
   } exp_t;
   exp_t sb[$];

   color_fsm_sequencer #(.NUM_REQ(2), .RESET_STATE(2'h1)) dut (
      .clk(clk), .rst(rst), .req(req), .tgt(tgt), .ack(ack), .err(err),
      .fsm_in(fsm_in), .fsm_out(fsm_out), .cur_state(cur_state),
      .busy(busy), .fault(fault)
   );

   always #5 clk = ~clk;

   // Controlled machine: 0 Blue, 1 Red (reset), 2 HSV idle; code 3 holds
   logic [1:0] m_state;
   logic       force_en = 1'b0;
   always @(posedge clk) begin
      if (rst) m_state <= 2'd1;
      else begin
         case ({m_state, fsm_in})
            {2'd0, 2'd1}: m_state <= 2'd1;
            {2'd1, 2'd1}: m_state <= 2'd0;
            {2'd1, 2'd2}: m_state <= 2'd2;
            {2'd2, 2'd0}: m_state <= 2'd1;
            default: ;
         endcase
      end
   end
   assign fsm_out = force_en ? 2'd2 : ((m_state == 2'd0) ? 2'd1 : 2'd2);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void push_exp(input int i, input bit e, input int l,
                                    input logic [7:0] c, input logic [1:0] s, input bit f);
      exp_t x;
      x.idx = i; x.err = e; x.lat = l; x.cmds = c; x.st = s; x.flt = f;
      sb.push_back(x);
   endfunction

   // Monitor: latency counts busy cycles since the last IDLE; cmds packs fsm_in
   // of cycles 1..4 (cycle 1 in the top bits, unused slots stay 3)
   bit         mon_en = 1'b0;
   logic [1:0] prev_ack = '0;
   int         lat = 0;
   logic [7:0] trace = 8'hFF;
   always @(negedge clk) begin
      if (mon_en) begin
         exp_t e;
         if (prev_ack != 2'b00) chk("ack_pulse", 32'(ack), 32'd0);
         prev_ack = ack;
         if (!busy) begin
            lat   = 0;
            trace = 8'hFF;
         end else begin
            lat++;
            if (lat <= 4) trace[2*(4-lat) +: 2] = fsm_in;
         end
         if (ack != 2'b00) begin
            if (sb.size() == 0) chk("unexpected_ack", 32'(ack), 32'd0);
            else begin
               e = sb.pop_front();
               chk("ack_idx",   32'(ack),       32'd1 << e.idx);
               chk("ack_err",   32'(err),       32'(e.err));
               chk("latency",   32'(lat),       32'(e.lat));
               chk("cmds",      32'(trace),     32'(e.cmds));
               chk("cur_state", 32'(cur_state), 32'(e.st));
               chk("fault",     32'(fault),     32'(e.flt));
            end
         end
      end
   end

   task automatic wait_ack(input int i);
      bit seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (((ack >> i) & 2'b01) != 2'b00) seen = 1'b1;
      end
      chk("ack_seen", 32'(seen), 32'd1);
   endtask

   task automatic do_req(input int i, input logic [1:0] t);
      @(negedge clk);
      tgt = (tgt & ~(4'h3 << (2*i))) | (4'(t) << (2*i));
      req = req | (2'b01 << i);
      wait_ack(i);
      req = req & ~(2'b01 << i);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; req = '0; tgt = '0;
      repeat (3) @(negedge clk);
      chk("rst_cur_state", 32'(cur_state), 32'd1);
      chk("rst_fsm_in",    32'(fsm_in),    32'd3);
      chk("rst_ack",       32'(ack),       32'd0);
      chk("rst_err",       32'(err),       32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_fault",     32'(fault),     32'd0);
      rst = 1'b0;
      mon_en = 1'b1;

      // Red -> HSV: one step, code 2
      push_exp(0, 1'b0, 3, 8'hBF, 2'd2, 1'b0);
      do_req(0, 2'd2);
      // HSV -> Blue: codes 0,1
      push_exp(1, 1'b0, 4, 8'h1F, 2'd0, 1'b0);
      do_req(1, 2'd0);

      // Both requesting: grants 0 (Blue, zero-step), 1 (Red), 0 (Blue)
      push_exp(0, 1'b0, 2, 8'hFF, 2'd0, 1'b0);
      push_exp(1, 1'b0, 3, 8'h7F, 2'd1, 1'b0);
      push_exp(0, 1'b0, 3, 8'h7F, 2'd0, 1'b0);
      @(negedge clk);
      tgt = {2'd1, 2'd0};
      req = 2'b11;
      wait_ack(0);
      req = 2'b10;
      @(negedge clk);
      req = 2'b11;
      wait_ack(1);
      req = 2'b01;
      wait_ack(0);
      req = 2'b00;

      // Invalid target, then target equal to shadow
      push_exp(0, 1'b1, 1, 8'hFF, 2'd0, 1'b0);
      do_req(0, 2'd3);
      push_exp(1, 1'b0, 2, 8'hFF, 2'd0, 1'b0);
      do_req(1, 2'd0);

      // Output mismatch sets fault; later requests fail immediately
      force_en = 1'b1;
      push_exp(0, 1'b1, 2, 8'hFF, 2'd0, 1'b1);
      do_req(0, 2'd0);
      force_en = 1'b0;
      push_exp(1, 1'b1, 1, 8'hFF, 2'd0, 1'b1);
      do_req(1, 2'd1);

      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst2_fault",     32'(fault),     32'd0);
      chk("rst2_cur_state", 32'(cur_state), 32'd1);
      rst = 1'b0;

      // Red -> Blue, then reset in the second step of Blue -> HSV
      push_exp(0, 1'b0, 3, 8'h7F, 2'd0, 1'b0);
      do_req(0, 2'd0);
      @(negedge clk);
      tgt = {2'd2, 2'd0};
      req = 2'b10;
      @(negedge clk);
      chk("b2h_step1", 32'(fsm_in), 32'd1);
      @(negedge clk);
      chk("b2h_step2", 32'(fsm_in), 32'd2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      req = 2'b00;
      chk("abort_ack",       32'(ack),       32'd0);
      chk("abort_cur_state", 32'(cur_state), 32'd1);
      chk("abort_fsm_in",    32'(fsm_in),    32'd3);
      chk("abort_busy",      32'(busy),      32'd0);
      repeat (6) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
